// File: rtl/aes_iter_enc.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Blocks are accepted and delivered over valid/ready handshakes.
module aes_iter_enc #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] plaintext,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] ciphertext,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] RN_LAST = 4'(NR);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as x^254 (product of x^2..x^128), then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte 4c+r holds row r of column c; row r rotates left by r columns.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = sbox(s[8*(4*((c+r)%4)+r) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    logic [1:0]   state_q, state_d;
    logic [0:127] st_q, st_d;
    logic [0:127] rk_q, rk_d;
    logic [3:0]   rn_q, rn_d;

    logic [31:0]  w0, w1, w2, w3, t;
    logic [0:127] nk, sr, mc;

    assign w0 = rk_q[0:31];
    assign w1 = rk_q[32:63];
    assign w2 = rk_q[64:95];
    assign w3 = rk_q[96:127];
    assign t  = {sbox(w3[23:16]) ^ rcon(rn_q), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign nk = {w0 ^ t, w0 ^ t ^ w1, w0 ^ t ^ w1 ^ w2, w0 ^ t ^ w1 ^ w2 ^ w3};
    assign sr = sub_shift(st_q);
    assign mc = mix_columns(sr);

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rn_d    = rn_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = plaintext ^ key;
                    rk_d    = key;
                    rn_d    = 4'd1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rk_d = nk;
                if (rn_q == RN_LAST) begin
                    st_d    = sr ^ nk;
                    state_d = S_DONE;
                end else begin
                    st_d = mc ^ nk;
                    rn_d = rn_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            rn_q    <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rn_q    <= rn_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = !in_ready;
    assign ciphertext = st_q;

endmodule

// File: tb/tb_aes_iter_enc.sv
// Directed bench for aes_iter_enc: FIPS-197 vectors, backpressure, isolation,
// mid-run reset, a single-round instance and back-to-back throughput.
module tb_aes_iter_enc;

    localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    // FIPS-197 App. B round 1: ShiftRows(SubBytes(p^k)) ^ round key 1, no MixColumns.
    localparam logic [0:127] CT_B_1 = 128'h7445a32768e07e1f9be228c8344beee0;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_valid1, out_ready;
    logic [0:127] plaintext, key;
    logic         in_ready, out_valid, busy;
    logic [0:127] ciphertext;
    logic         in_ready1, out_valid1, busy1;
    logic [0:127] ciphertext1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    aes_iter_enc #(.NR(10)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
    );

    aes_iter_enc #(.NR(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .plaintext(plaintext), .key(key), .out_valid(out_valid1),
        .out_ready(out_ready), .ciphertext(ciphertext1), .busy(busy1)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents a block to the NR=10 engine and returns just after the acceptance edge.
    task automatic accept(input logic [0:127] pt, input logic [0:127] k);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        for (int n = 0; n < 50 && !in_ready; n++) step;
        step;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            step;
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0;
        plaintext = '0; key = '0;
        step; step;
        reset = 1'b0;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (ciphertext !== 128'h0) begin mismatched++; $display("FAIL reset_ct: got %h want 0", ciphertext); end
    endtask

    task automatic test_fips_b;
        int n;
        out_ready = 1'b1;
        accept(PT_B, KEY_B);
        compared++; if (busy !== 1'b1 || in_ready !== 1'b0) begin mismatched++; $display("FAIL fipsb_busy: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
        wait_out(n);
        compared++; if (n != 10) begin mismatched++; $display("FAIL fipsb_latency: got %0d want 10", n); end
        compared++; if (ciphertext !== CT_B) begin mismatched++; $display("FAIL fipsb_ct: got %h want %h", ciphertext, CT_B); end
        step;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL fipsb_ov_pulse: got %b want 0", out_valid); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL fipsb_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_fips_c1;
        int n;
        out_ready = 1'b1;
        accept(PT_C, KEY_C);
        wait_out(n);
        compared++; if (n != 10) begin mismatched++; $display("FAIL fipsc_latency: got %0d want 10", n); end
        compared++; if (ciphertext !== CT_C) begin mismatched++; $display("FAIL fipsc_ct: got %h want %h", ciphertext, CT_C); end
        step;
    endtask

    task automatic test_backpressure;
        int n;
        out_ready = 1'b0;
        accept(PT_B, KEY_B);
        plaintext = PT_C;
        key       = KEY_C;
        in_valid  = 1'b1;
        wait_out(n);
        compared++; if (n != 10) begin mismatched++; $display("FAIL bp_latency: got %0d want 10", n); end
        for (int i = 0; i < 20; i++) begin
            step;
            compared++; if (ciphertext !== CT_B || out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_hold[%0d]: got %h ov=%b want %h ov=1", i, ciphertext, out_valid, CT_B); end
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        step;
        compared++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release: got in_ready=%b ov=%b want 1/0", in_ready, out_valid); end
        step;
        in_valid = 1'b0;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL bp_second_accept: got busy=%b want 1", busy); end
        wait_out(n);
        compared++; if (n != 10) begin mismatched++; $display("FAIL bp_second_latency: got %0d want 10", n); end
        compared++; if (ciphertext !== CT_C) begin mismatched++; $display("FAIL bp_second_ct: got %h want %h", ciphertext, CT_C); end
        step;
    endtask

    task automatic test_isolation;
        int n;
        out_ready = 1'b1;
        accept(PT_B, KEY_B);
        n = 0;
        while (!out_valid && n < 40) begin
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = 1'($urandom_range(0, 1));
            step;
            n++;
        end
        in_valid = 1'b0;
        compared++; if (n != 10) begin mismatched++; $display("FAIL iso_latency: got %0d want 10", n); end
        compared++; if (ciphertext !== CT_B) begin mismatched++; $display("FAIL iso_ct: got %h want %h", ciphertext, CT_B); end
        step; step;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL iso_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int  n;
        logic seen;
        out_ready = 1'b1;
        accept(PT_B, KEY_B);
        for (int i = 0; i < 5; i++) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        compared++; if (ciphertext !== 128'h0) begin mismatched++; $display("FAIL rmid_ct: got %h want 0", ciphertext); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step;
            if (out_valid) seen = 1'b1;
        end
        compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL rmid_no_output: got out_valid seen=%b want 0", seen); end
        accept(PT_C, KEY_C);
        wait_out(n);
        compared++; if (ciphertext !== CT_C) begin mismatched++; $display("FAIL rmid_next_ct: got %h want %h", ciphertext, CT_C); end
        step;
    endtask

    task automatic test_nr1;
        out_ready = 1'b1;
        plaintext = PT_B;
        key       = KEY_B;
        in_valid1 = 1'b1;
        step;
        in_valid1 = 1'b0;
        compared++; if (out_valid1 !== 1'b0 || busy1 !== 1'b1) begin mismatched++; $display("FAIL nr1_run: got ov=%b busy=%b want 0/1", out_valid1, busy1); end
        step;
        compared++; if (out_valid1 !== 1'b1) begin mismatched++; $display("FAIL nr1_latency: got ov=%b want 1", out_valid1); end
        compared++; if (ciphertext1 !== CT_B_1) begin mismatched++; $display("FAIL nr1_ct: got %h want %h", ciphertext1, CT_B_1); end
        step;
        compared++; if (in_ready1 !== 1'b1) begin mismatched++; $display("FAIL nr1_idle: got %b want 1", in_ready1); end
    endtask

    task automatic test_back_to_back;
        int outs = 0;
        int cyc  = 0;
        int last = -1;
        out_ready = 1'b1;
        plaintext = PT_B;
        key       = KEY_B;
        in_valid  = 1'b1;
        while (outs < 4 && cyc < 100) begin
            step;
            cyc++;
            if (out_valid) begin
                compared++; if (ciphertext !== CT_B) begin mismatched++; $display("FAIL b2b_ct[%0d]: got %h want %h", outs, ciphertext, CT_B); end
                if (last >= 0) begin
                    compared++; if (cyc - last != 12) begin mismatched++; $display("FAIL b2b_period[%0d]: got %0d want 12", outs, cyc - last); end
                end
                last = cyc;
                outs++;
                if (outs == 4) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        compared++; if (outs != 4) begin mismatched++; $display("FAIL b2b_count: got %0d want 4", outs); end
        step; step;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset;
        test_fips_b;
        test_fips_c1;
        test_backpressure;
        test_isolation;
        test_reset_mid;
        test_nr1;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
